// File: rtl/uarc_char_bridge.sv
// +---------------------------------------------------------------------------+
// | uarc_char_bridge : per-channel RX/TX character FIFOs between character    |
// |   sources/sinks and the UARC core bus handshakes. Optional local echo is  |
// |   enabled by defining UARC_CHAR_BRIDGE_ECHO_EN.                           |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

module uarc_char_bridge #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAR_WIDTH   = 7,
  parameter int CHANNELS     = 1,
  parameter int RX_DEPTH_MAG = 3,
  parameter int TX_DEPTH_MAG = 3
) (
  input  logic                           clk,
  input  logic                           reset_b,
  input  logic [CHANNELS-1:0]            src_valid,
  input  logic [CHANNELS*CHAR_WIDTH-1:0] src_char,
  output logic [CHANNELS-1:0]            receiver_sends,
  input  logic [CHANNELS-1:0]            receiver_send_acks,
  output logic [CHANNELS*WORD_WIDTH-1:0] receiver_datas,
  input  logic                           global_send,
  input  logic [WORD_WIDTH-1:0]          global_data,
  input  logic [CHANNELS-1:0]            sender_enables,
  output logic [CHANNELS-1:0]            sender_send_acks,
  output logic [CHANNELS-1:0]            sink_valid,
  output logic [CHANNELS*CHAR_WIDTH-1:0] sink_char,
  input  logic [CHANNELS-1:0]            sink_ready,
  output logic [CHANNELS-1:0]            rx_overflow,
  input  logic [CHANNELS-1:0]            overflow_clear
);

  localparam int RX_DEPTH = 1 << RX_DEPTH_MAG;
  localparam int TX_DEPTH = 1 << TX_DEPTH_MAG;

  // Only the low CHAR_WIDTH bits of the core word carry a character.
  logic unused_global_data;
  assign unused_global_data = ^global_data;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [CHAR_WIDTH-1:0]   rx_mem_q [RX_DEPTH];
    logic [RX_DEPTH_MAG-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_DEPTH_MAG:0]   rx_cnt_q, rx_cnt_d;
    logic                    rx_ovf_q, rx_ovf_d;
    logic [CHAR_WIDTH-1:0]   tx_mem_q [TX_DEPTH];
    logic [TX_DEPTH_MAG-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_DEPTH_MAG:0]   tx_cnt_q, tx_cnt_d;

    logic                    rx_empty, rx_full, rx_push, rx_pop, rx_drop;
    logic                    tx_empty, tx_full, tx_push, tx_pop, tx_ack, echo_push;
    logic [CHAR_WIDTH-1:0]   src_c, tx_wdata, rx_head, tx_head;
    logic [WORD_WIDTH-1:0]   rx_word;

    assign src_c    = src_char[c*CHAR_WIDTH +: CHAR_WIDTH];
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = rx_cnt_q[RX_DEPTH_MAG];
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = tx_cnt_q[TX_DEPTH_MAG];

    // A full RX still accepts when the head is popped in the same cycle.
    assign rx_pop  = receiver_send_acks[c] & ~rx_empty;
    assign rx_push = src_valid[c] & (~rx_full | rx_pop);
    assign rx_drop = src_valid[c] & ~rx_push;

`ifdef UARC_CHAR_BRIDGE_ECHO_EN
    assign echo_push = rx_push & ~tx_full;
`else
    assign echo_push = 1'b0;
`endif

    // Accept uses registered full only, so a concurrent sink pop does not help.
    assign tx_ack   = global_send & sender_enables[c] & ~tx_full & ~echo_push;
    assign tx_push  = tx_ack | echo_push;
    assign tx_pop   = ~tx_empty & sink_ready[c];
    assign tx_wdata = echo_push ? src_c : global_data[CHAR_WIDTH-1:0];

    always_comb begin
      rx_wptr_d = rx_push ? rx_wptr_q + RX_DEPTH_MAG'(1) : rx_wptr_q;
      rx_rptr_d = rx_pop  ? rx_rptr_q + RX_DEPTH_MAG'(1) : rx_rptr_q;
      rx_cnt_d  = rx_cnt_q;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + (RX_DEPTH_MAG+1)'(1);
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (RX_DEPTH_MAG+1)'(1);
      rx_ovf_d  = rx_drop ? 1'b1 : (overflow_clear[c] ? 1'b0 : rx_ovf_q);
      tx_wptr_d = tx_push ? tx_wptr_q + TX_DEPTH_MAG'(1) : tx_wptr_q;
      tx_rptr_d = tx_pop  ? tx_rptr_q + TX_DEPTH_MAG'(1) : tx_rptr_q;
      tx_cnt_d  = tx_cnt_q;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + (TX_DEPTH_MAG+1)'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (TX_DEPTH_MAG+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
        rx_wptr_q <= '0;
        rx_rptr_q <= '0;
        rx_cnt_q  <= '0;
        rx_ovf_q  <= 1'b0;
        tx_wptr_q <= '0;
        tx_rptr_q <= '0;
        tx_cnt_q  <= '0;
      end else begin
        rx_wptr_q <= rx_wptr_d;
        rx_rptr_q <= rx_rptr_d;
        rx_cnt_q  <= rx_cnt_d;
        rx_ovf_q  <= rx_ovf_d;
        tx_wptr_q <= tx_wptr_d;
        tx_rptr_q <= tx_rptr_d;
        tx_cnt_q  <= tx_cnt_d;
      end
    end

    // Storage is not reset; empty FIFOs mask their head to zero instead.
    always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wptr_q] <= src_c;
      if (tx_push) tx_mem_q[tx_wptr_q] <= tx_wdata;
    end

    assign rx_head = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
    assign tx_head = tx_empty ? '0 : tx_mem_q[tx_rptr_q];

    always_comb begin
      rx_word = '0;
      rx_word[CHAR_WIDTH-1:0] = rx_head;
    end

    assign receiver_sends[c]                         = ~rx_empty;
    assign receiver_datas[c*WORD_WIDTH +: WORD_WIDTH] = rx_word;
    assign sender_send_acks[c]                       = tx_ack;
    assign sink_valid[c]                             = ~tx_empty;
    assign sink_char[c*CHAR_WIDTH +: CHAR_WIDTH]     = tx_head;
    assign rx_overflow[c]                            = rx_ovf_q;
  end : g_chan

endmodule

`default_nettype wire

// File: tb/tb_uarc_char_bridge.sv
// +---------------------------------------------------------------------------+
// | tb_uarc_char_bridge : directed self-checking bench, two-channel build.    |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_uarc_char_bridge;

  localparam int WW = 32;
  localparam int CW = 7;
  localparam int CH = 2;

  logic           clk;
  logic           reset_b;
  logic [CH-1:0]  src_valid;
  logic [CH*CW-1:0] src_char;
  logic [CH-1:0]  receiver_sends;
  logic [CH-1:0]  receiver_send_acks;
  logic [CH*WW-1:0] receiver_datas;
  logic           global_send;
  logic [WW-1:0]  global_data;
  logic [CH-1:0]  sender_enables;
  logic [CH-1:0]  sender_send_acks;
  logic [CH-1:0]  sink_valid;
  logic [CH*CW-1:0] sink_char;
  logic [CH-1:0]  sink_ready;
  logic [CH-1:0]  rx_overflow;
  logic [CH-1:0]  overflow_clear;

  int errors = 0;
  int checks = 0;

  uarc_char_bridge #(
    .WORD_WIDTH(WW), .CHAR_WIDTH(CW), .CHANNELS(CH),
    .RX_DEPTH_MAG(3), .TX_DEPTH_MAG(3)
  ) u_dut (
    .clk(clk), .reset_b(reset_b),
    .src_valid(src_valid), .src_char(src_char),
    .receiver_sends(receiver_sends), .receiver_send_acks(receiver_send_acks),
    .receiver_datas(receiver_datas),
    .global_send(global_send), .global_data(global_data),
    .sender_enables(sender_enables), .sender_send_acks(sender_send_acks),
    .sink_valid(sink_valid), .sink_char(sink_char), .sink_ready(sink_ready),
    .rx_overflow(rx_overflow), .overflow_clear(overflow_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset_b            = 1'b0;
    src_valid          = '0;
    src_char           = '0;
    receiver_send_acks = '0;
    global_send        = 1'b0;
    global_data        = '0;
    sender_enables     = '0;
    sink_ready         = '0;
    overflow_clear     = '0;

    // Reset state
    repeat (3) step();
    check("rst_rx_sends", 64'(receiver_sends), 64'd0);
    check("rst_sink_valid", 64'(sink_valid), 64'd0);
    check("rst_overflow", 64'(rx_overflow), 64'd0);
    check("rst_rx_data", receiver_datas, 64'd0);
    check("rst_sink_char", 64'(sink_char), 64'd0);
    check("rst_send_ack", 64'(sender_send_acks), 64'd0);
    reset_b    = 1'b1;
    sink_ready = 2'b11;   // drains any echoed characters in the echo build
    step();

    // Single character and ack
    src_valid = 2'b01; src_char[CW-1:0] = 7'h41;
    step();
    src_valid = '0;
    settle();
    check("rx1_sends", 64'(receiver_sends), 64'd1);
    check("rx1_data", 64'(receiver_datas[WW-1:0]), 64'h41);
    receiver_send_acks = 2'b01;
    step();
    receiver_send_acks = '0;
    settle();
    check("rx1_after_ack", 64'(receiver_sends), 64'd0);

    // Overflow: 9 pushes into depth 8
    for (int i = 0; i < 9; i++) begin
      src_valid = 2'b01; src_char[CW-1:0] = 7'(8'h30 + i);
      step();
    end
    src_valid = '0;
    settle();
    check("ovf_set", 64'(rx_overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain%0d", i), 64'(receiver_datas[WW-1:0]), 64'(8'h30 + i));
      receiver_send_acks = 2'b01;
      step();
    end
    receiver_send_acks = '0;
    settle();
    check("ovf_empty", 64'(receiver_sends), 64'd0);
    receiver_send_acks = 2'b01;   // ack on empty is ignored
    step();
    receiver_send_acks = '0;
    settle();
    check("empty_ack_ignored", 64'(receiver_sends), 64'd0);
    check("ovf_sticky", 64'(rx_overflow), 64'd1);
    overflow_clear = 2'b01;
    step();
    overflow_clear = '0;
    settle();
    check("ovf_cleared", 64'(rx_overflow), 64'd0);

    // Full RX with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      src_valid = 2'b01; src_char[CW-1:0] = 7'(8'h50 + i);
      step();
    end
    src_valid = 2'b01; src_char[CW-1:0] = 7'h58; receiver_send_acks = 2'b01;
    step();
    src_valid = '0; receiver_send_acks = '0;
    settle();
    check("fullpp_no_ovf", 64'(rx_overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fullpp_drain%0d", i), 64'(receiver_datas[WW-1:0]), 64'(8'h51 + i));
      receiver_send_acks = 2'b01;
      step();
    end
    receiver_send_acks = '0;
    settle();
    check("fullpp_empty", 64'(receiver_sends), 64'd0);

    // TX fill with sink stalled
    sink_ready = '0;
    repeat (3) step();
    global_send = 1'b1; sender_enables = 2'b01;
    for (int i = 0; i < 9; i++) begin
      global_data = 32'(8'h48 + i);
      settle();
      check($sformatf("tx_ack%0d", i), 64'(sender_send_acks), (i < 8) ? 64'd1 : 64'd0);
      step();
    end
    global_data = 32'h60; sink_ready = 2'b01;
    settle();
    check("tx_full_pp_refused", 64'(sender_send_acks), 64'd0);
    check("tx_head0", 64'(sink_char[CW-1:0]), 64'h48);
    step();
    settle();
    check("tx_ack_after_pop", 64'(sender_send_acks), 64'd1);
    check("tx_head1", 64'(sink_char[CW-1:0]), 64'h49);
    step();
    global_send = 1'b0; sender_enables = '0;
    settle();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("tx_drain%0d", i), 64'(sink_char[CW-1:0]),
            (i < 6) ? 64'(8'h4A + i) : 64'h60);
      step();
    end
    sink_ready = '0;
    settle();
    check("tx_empty", 64'(sink_valid), 64'd0);

    // Two channels: src on ch1, send on ch0
    src_valid = 2'b10; src_char = {7'h33, 7'h00};
    global_send = 1'b1; global_data = 32'h44; sender_enables = 2'b01;
    settle();
    check("mc_ack", 64'(sender_send_acks), 64'd1);
    step();
    src_valid = '0; global_send = 1'b0; sender_enables = '0;
    settle();
    check("mc_rx_sends", 64'(receiver_sends), 64'b10);
    check("mc_rx_data", receiver_datas, {32'h33, 32'h0});
`ifdef UARC_CHAR_BRIDGE_ECHO_EN
    check("mc_sink_valid", 64'(sink_valid), 64'b11);
    check("mc_sink_char", 64'(sink_char), 64'({7'h33, 7'h44}));
`else
    check("mc_sink_valid", 64'(sink_valid), 64'b01);
    check("mc_sink_char", 64'(sink_char), 64'({7'h00, 7'h44}));
`endif
    receiver_send_acks = 2'b10; sink_ready = 2'b11;
    step();
    receiver_send_acks = '0;
    settle();
    check("mc_all_empty", 64'({receiver_sends, sink_valid}), 64'd0);
    sink_ready = '0;
    global_send = 1'b1; global_data = 32'h22; sender_enables = 2'b11;
    settle();
    check("mc_both_ack", 64'(sender_send_acks), 64'b11);
    step();
    global_send = 1'b0; sender_enables = '0;
    settle();
    check("mc_both_sink", 64'(sink_char), 64'({7'h22, 7'h22}));
    sink_ready = 2'b11;
    step();
    sink_ready = '0;

`ifdef UARC_CHAR_BRIDGE_ECHO_EN
    // Echo takes priority over a core send
    src_valid = 2'b01; src_char = {7'h00, 7'h61};
    global_send = 1'b1; global_data = 32'h62; sender_enables = 2'b01;
    settle();
    check("echo_ack_withheld", 64'(sender_send_acks), 64'd0);
    step();
    src_valid = '0;
    settle();
    check("echo_ack_retry", 64'(sender_send_acks), 64'd1);
    step();
    global_send = 1'b0; sender_enables = '0;
    settle();
    check("echo_sink0", 64'(sink_char[CW-1:0]), 64'h61);
    sink_ready = 2'b01;
    step();
    check("echo_sink1", 64'(sink_char[CW-1:0]), 64'h62);
    step();
    sink_ready = '0;
    receiver_send_acks = 2'b01;
    step();
    receiver_send_acks = '0;
    settle();
    check("echo_empty", 64'({receiver_sends, sink_valid}), 64'd0);
`endif

    // Asynchronous reset mid-operation
    src_valid = 2'b01; src_char = {7'h00, 7'h11};
    global_send = 1'b1; global_data = 32'h12; sender_enables = 2'b10;
    step();
    src_valid = '0; global_send = 1'b0; sender_enables = '0;
    settle();
    check("arst_pre_rx", 64'(receiver_sends), 64'd1);
    reset_b = 1'b0;
    #1;
    check("arst_rx_sends", 64'(receiver_sends), 64'd0);
    check("arst_sink_valid", 64'(sink_valid), 64'd0);
    check("arst_rx_data", receiver_datas, 64'd0);
    step();
    reset_b = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uarc_char_bridge.md
# uarc_char_bridge

Parametrised, FIFO-buffered character bridge between keyboard-style character sources, the UARC core's receiver/sender bus handshakes, and terminal-style character sinks. It replaces the single-entry keyboard latch and the unbuffered terminal write path with per-channel RX and TX FIFOs for CHANNELS independent buses. It adds sticky overflow reporting and optional local echo. It sits at the top level between the PS/2 ASCII decoders and VGA terminals on one side and the core's bus ports on the other.

## Interface
- WORD_WIDTH, 32, core word width; receiver data is the character zero-extended to this width
- CHAR_WIDTH, 7, character width in bits; 1 ≤ CHAR_WIDTH ≤ WORD_WIDTH
- CHANNELS, 1, number of independent bridged buses
- RX_DEPTH_MAG, 3, log2 of RX FIFO depth per channel (depth 8)
- TX_DEPTH_MAG, 3, log2 of TX FIFO depth per channel (depth 8)

Ports:
- clk  in  1  single clock, rising edge
- reset_b  in  1  asynchronous, active-low reset
- src_valid  in  CHANNELS  one-cycle pulse: new character from source c (no backpressure)
- src_char  in  CHANNELS*CHAR_WIDTH  character for channel c at [c*CHAR_WIDTH +: CHAR_WIDTH]
- receiver_sends  out  CHANNELS  RX FIFO c non-empty
- receiver_send_acks  in  CHANNELS  core consumed the head of RX FIFO c
- receiver_datas  out  CHANNELS*WORD_WIDTH  head of RX FIFO c, zero-extended
- global_send  in  1  core is sending global_data this cycle
- global_data  in  WORD_WIDTH  core send data; bits [CHAR_WIDTH-1:0] are used
- sender_enables  in  CHANNELS  core's send targets this cycle
- sender_send_acks  out  CHANNELS  send to channel c accepted (combinational)
- sink_valid  out  CHANNELS  TX FIFO c non-empty
- sink_char  out  CHANNELS*CHAR_WIDTH  head of TX FIFO c
- sink_ready  in  CHANNELS  sink c consumes its head when sink_valid[c] is also high
- rx_overflow  out  CHANNELS  sticky: a source character was dropped on channel c
- overflow_clear  in  CHANNELS  clears rx_overflow[c]

## Operation
- Each channel has one RX FIFO and one TX FIFO. Both are show-ahead circular buffers with wrapping read and write pointers and an occupancy count of width DEPTH_MAG+1.
- RX push: src_valid[c] is accepted if RX c is not full, or if receiver_send_acks[c] pops in the same cycle. Otherwise the character is dropped and rx_overflow[c] is set.
- RX pop: receiver_send_acks[c] while receiver_sends[c] is high. An ack while the FIFO is empty is ignored.
- Simultaneous push and pop leaves the count unchanged.
- TX accept: sender_send_acks[c] = global_send & sender_enables[c] & TX c not full & no echo push on c this cycle. On an ack, global_data[CHAR_WIDTH-1:0] is pushed.
- Unacked channels are not retried by this block; the core holds global_send until it sees the ack.
- TX pop: sink_valid[c] & sink_ready[c].
- Simultaneous TX push and pop on a full FIFO: the push is refused, because the accept decision uses only the registered full state.
- rx_overflow[c]: if overflow_clear[c] and a new drop occur in the same cycle, the set wins.
- Channels are fully independent; any combination of events on different channels in the same cycle is legal.

## Timing
- Reset (asynchronous assert, synchronous use after deassert) sets:
  - all FIFOs empty and all pointers 0
  - receiver_sends = 0, sink_valid = 0, rx_overflow = 0
  - receiver_datas = 0 and sink_char = 0 while empty
- sender_send_acks is combinational: 0 whenever global_send = 0.
- RX latency: src_valid at edge N makes receiver_sends high after edge N (visible in cycle N+1) with receiver_datas valid.
- An ack at edge M advances the head after M. Back-to-back acks drain one entry per cycle.
- TX latency: an accepted send at edge N makes sink_valid high in cycle N+1.
- Reset asserted mid-operation discards all buffered characters immediately. Outputs go to reset values without waiting for a clock.
- Output data while the FIFO is empty is don't-care but must not be X after reset.

## Configuration
- UARC_CHAR_BRIDGE_ECHO_EN defined:
  - Every character accepted into RX c is also pushed into TX c in the same cycle, if TX c is not full. If TX c is full, the echo is silently dropped.
  - In a cycle with an echo push on c, sender_send_acks[c] is forced 0 and the core retries.
- UARC_CHAR_BRIDGE_ECHO_EN undefined: there is no echo path, and TX c is written only by core sends.

## Test plan
- Reset, then src_valid pulse with char 0x41 on channel 0 -> receiver_sends[0] = 1 next cycle, receiver_datas[31:0] = 0x0000_0041. Ack -> receiver_sends[0] = 0 next cycle.
- Default depth 8, 9 src pulses (0x30..0x38) with no acks -> first 8 retained, rx_overflow[0] = 1. Acks yield 0x30..0x37 in order. overflow_clear -> rx_overflow[0] = 0.
- RX full, src_valid and receiver_send_acks in the same cycle -> no overflow, count stays 8, new char appears last.
- global_send with sender_enables = 1 and data 0x0000_0048, sink_ready = 0 for 9 sends -> 8 acks then sender_send_acks = 0. Raising sink_ready drains 0x48 once per cycle.
- CHANNELS = 2: concurrent src on ch1 and send on ch0 -> independent results, no cross-channel leakage.
- With ECHO_EN, src 0x61 on ch0 while the core sends 0x62 -> echo 0x61 enters TX first, ack withheld that cycle, 0x62 acked next cycle. Sink order is 0x61, 0x62.
